// File: rtl/up_bus_responder.sv
// up_bus_responder: byte-wide four-phase uP handshake responder. It collects a 6-byte
// command packet, strobes the motion-system register bank once and returns status/read data.
module up_bus_responder #(
  parameter int NOS_REGISTERS = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uP_start,
  input  logic        uP_handshake_1,
  input  logic [7:0]  uP_data_out,
  output logic        uP_ack,
  output logic        uP_handshake_2,
  output logic [7:0]  uP_data_in,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_wdata,
  output logic        reg_write,
  output logic        reg_read,
  input  logic [31:0] reg_rdata
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RX_WAIT    = 4'd1,
    S_RX_ACK     = 4'd2,
    S_EXECUTE    = 4'd3,
    S_READ_WAIT  = 4'd4,
    S_TX_SETUP   = 4'd5,
    S_TX_DRIVE   = 4'd6,
    S_TX_RELEASE = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  function automatic logic [7:0] f_status(input logic [7:0] cmd, input logic [7:0] addr);
    logic [31:0] addr_ext;
    addr_ext = {24'd0, addr};
    if ((cmd != 8'd1) && (cmd != 8'd2)) begin
      f_status = 8'h01;
    end else if (addr_ext >= 32'(NOS_REGISTERS)) begin
      f_status = 8'h02;
    end else begin
      f_status = 8'h00;
    end
  endfunction

  function automatic logic [7:0] f_reply(input logic [2:0] idx, input logic [7:0] status,
                                         input logic [31:0] rdata);
    case (idx)
      3'd0:    f_reply = status;
      3'd1:    f_reply = rdata[7:0];
      3'd2:    f_reply = rdata[15:8];
      3'd3:    f_reply = rdata[23:16];
      3'd4:    f_reply = rdata[31:24];
      default: f_reply = 8'h00;
    endcase
  endfunction

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_start_sync, r_h1_sync;
  logic                   w_start, w_h1, w_abort;
  logic [5:0][7:0]        r_bytes;
  logic [2:0]             r_count, w_count_next, r_idx, w_idx_next, w_tx_len;
  logic [31:0]            r_rdata, r_wdata, w_wdata_next;
  logic [7:0]             r_data_in, w_data_in_next, r_address, w_address_next, w_status;
  logic                   r_ack, w_ack_next, r_hs2, w_hs2_next;
  logic                   r_write, w_write_next, r_read, w_read_next;
  logic                   w_latch_byte, w_capture_rdata, w_read_ok, w_write_ok;

  assign w_start    = r_start_sync[SYNC_STAGES-1];
  assign w_h1       = r_h1_sync[SYNC_STAGES-1];
  assign w_status   = f_status(r_bytes[0], r_bytes[1]);
  assign w_write_ok = (r_bytes[0] == 8'd1) && (w_status == 8'h00);
  assign w_read_ok  = (r_bytes[0] == 8'd2) && (w_status == 8'h00);
  assign w_tx_len   = w_read_ok ? 3'd5 : 3'd1;
  assign w_abort    = !w_start && (r_state != S_IDLE) && (r_state != S_DONE);

  assign uP_ack         = r_ack;
  assign uP_handshake_2 = r_hs2;
  assign uP_data_in     = r_data_in;
  assign reg_address    = r_address;
  assign reg_wdata      = r_wdata;
  assign reg_write      = r_write;
  assign reg_read       = r_read;

  // Synchronisers for the asynchronous uP strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_sync <= {SYNC_STAGES{1'b0}};
      r_h1_sync    <= {SYNC_STAGES{1'b0}};
    end else begin
      r_start_sync[0] <= uP_start;
      r_h1_sync[0]    <= uP_handshake_1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_start_sync[i] <= r_start_sync[i-1];
        r_h1_sync[i]    <= r_h1_sync[i-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next output values; outputs are loaded on entry to the state that owns them.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_idx_next      = r_idx;
    w_ack_next      = r_ack;
    w_hs2_next      = r_hs2;
    w_data_in_next  = r_data_in;
    w_address_next  = r_address;
    w_wdata_next    = r_wdata;
    w_write_next    = 1'b0;
    w_read_next     = 1'b0;
    w_latch_byte    = 1'b0;
    w_capture_rdata = 1'b0;
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_hs2_next   = 1'b0;
      w_ack_next   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_count_next = 3'd0;
          w_idx_next   = 3'd0;
          w_hs2_next   = 1'b0;
          w_ack_next   = 1'b0;
          w_state_next = w_start ? S_RX_WAIT : S_IDLE;
        end
        S_RX_WAIT: begin
          if (w_h1) begin
            w_latch_byte = 1'b1;
            w_hs2_next   = 1'b1;
            w_state_next = S_RX_ACK;
          end else begin
            w_state_next = S_RX_WAIT;
          end
        end
        S_RX_ACK: begin
          if (!w_h1) begin
            w_hs2_next   = 1'b0;
            w_count_next = r_count + 3'd1;
            if (r_count == 3'd5) begin
              w_state_next   = S_EXECUTE;
              w_address_next = r_bytes[1];
              w_wdata_next   = {r_bytes[5], r_bytes[4], r_bytes[3], r_bytes[2]};
              w_write_next   = w_write_ok;
              w_read_next    = w_read_ok;
            end else begin
              w_state_next = S_RX_WAIT;
            end
          end else begin
            w_state_next = S_RX_ACK;
          end
        end
        S_EXECUTE: begin
          w_idx_next = 3'd0;
          if (w_read_ok) begin
            w_state_next = S_READ_WAIT;
          end else begin
            w_state_next   = S_TX_SETUP;
            w_data_in_next = w_status;
          end
        end
        S_READ_WAIT: begin
          w_capture_rdata = 1'b1;
          w_data_in_next  = w_status;
          w_state_next    = S_TX_SETUP;
        end
        S_TX_SETUP: begin
          w_hs2_next   = 1'b1;
          w_state_next = S_TX_DRIVE;
        end
        S_TX_DRIVE: begin
          if (w_h1) begin
            w_hs2_next   = 1'b0;
            w_state_next = S_TX_RELEASE;
          end else begin
            w_state_next = S_TX_DRIVE;
          end
        end
        S_TX_RELEASE: begin
          if (!w_h1) begin
            w_idx_next = r_idx + 3'd1;
            if ((r_idx + 3'd1) < w_tx_len) begin
              w_state_next   = S_TX_SETUP;
              w_data_in_next = f_reply(r_idx + 3'd1, w_status, r_rdata);
            end else begin
              w_state_next = S_DONE;
              w_ack_next   = 1'b1;
            end
          end else begin
            w_state_next = S_TX_RELEASE;
          end
        end
        S_DONE: begin
          if (!w_start) begin
            w_ack_next   = 1'b0;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DONE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Output, packet and reply registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= 3'd0;
      r_idx     <= 3'd0;
      r_ack     <= 1'b0;
      r_hs2     <= 1'b0;
      r_data_in <= 8'h00;
      r_address <= 8'h00;
      r_wdata   <= 32'h0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_bytes   <= {6{8'h00}};
      r_rdata   <= 32'h0;
    end else begin
      r_count   <= w_count_next;
      r_idx     <= w_idx_next;
      r_ack     <= w_ack_next;
      r_hs2     <= w_hs2_next;
      r_data_in <= w_data_in_next;
      r_address <= w_address_next;
      r_wdata   <= w_wdata_next;
      r_write   <= w_write_next;
      r_read    <= w_read_next;
      if (w_latch_byte) begin
        r_bytes[r_count] <= uP_data_out;
      end else begin
        r_bytes <= r_bytes;
      end
      if (w_capture_rdata) begin
        r_rdata <= reg_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

endmodule

// File: tb/tb_up_bus_responder.sv
// Bench for up_bus_responder: acts as the uP on the four-phase bus and as the register bank,
// checking every reply against a packet-level reference model.
module tb_up_bus_responder;
  localparam int NREG = 32;
  localparam int SYNC = 2;
  localparam int TMO  = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uP_start = 1'b0;
  logic        uP_handshake_1 = 1'b0;
  logic [7:0]  uP_data_out = 8'h00;
  logic        uP_ack, uP_handshake_2, reg_write, reg_read;
  logic [7:0]  uP_data_in, reg_address;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = 32'h0;

  up_bus_responder #(.NOS_REGISTERS(NREG), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .uP_start(uP_start), .uP_handshake_1(uP_handshake_1),
    .uP_data_out(uP_data_out), .uP_ack(uP_ack), .uP_handshake_2(uP_handshake_2),
    .uP_data_in(uP_data_in), .reg_address(reg_address), .reg_wdata(reg_wdata),
    .reg_write(reg_write), .reg_read(reg_read), .reg_rdata(reg_rdata)
  );

  always #10 clk = ~clk;

  // Register bank: read data is only valid in the cycle right after reg_read.
  logic [31:0] bank [0:NREG-1];
  always @(posedge clk) begin
    if (reg_write && reg_address < 8'(NREG)) bank[reg_address[4:0]] <= reg_wdata;
    reg_rdata <= (reg_read && reg_address < 8'(NREG)) ? bank[reg_address[4:0]] : $urandom;
  end

  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, proto_err = 0;
  logic [7:0]  last_waddr = 8'h00, last_raddr = 8'h00, prev_din = 8'h00;
  logic [31:0] last_wdata = 32'h0;
  logic        prev_w = 1'b0, prev_r = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe bookkeeping and cycle-level protocol rules.
  always @(negedge clk) begin
    prev_din <= uP_data_in;
    prev_w   <= reg_write;
    prev_r   <= reg_read;
    if (reset) begin
      if (reg_write) begin
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= reg_address;
        last_wdata <= reg_wdata;
      end
      if (reg_read) begin
        rd_cnt     <= rd_cnt + 1;
        last_raddr <= reg_address;
      end
      if ((reg_write && reg_read) || (reg_write && prev_w) || (reg_read && prev_r) ||
          (uP_handshake_2 && uP_data_in !== prev_din))
        proto_err <= proto_err + 1;
    end
  end

  int          n_checks = 0, n_fail = 0;
  int          t_seen = 0, t_rise = 0;
  logic [31:0] ref_mem [0:NREG-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs2(input logic val, input string tag);
    int n = 0;
    while (uP_handshake_2 !== val && n < TMO) begin
      @(negedge clk);
      n++;
    end
    t_seen = cyc;
    check(tag, {31'd0, uP_handshake_2}, {31'd0, val});
  endtask

  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    while (uP_ack !== val && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, uP_ack}, {31'd0, val});
  endtask

  task automatic send_byte(input logic [7:0] b, input int st);
    uP_data_out = b;
    repeat (st) @(negedge clk);
    check("rx_h2_low_before_h1", {31'd0, uP_handshake_2}, 32'd0);
    uP_handshake_1 = 1'b1;
    wait_hs2(1'b1, "rx_h2_rise");
    uP_data_out = 8'($urandom);
    repeat (st) @(negedge clk);
    uP_handshake_1 = 1'b0;
    wait_hs2(1'b0, "rx_h2_fall");
  endtask

  task automatic recv_byte(output logic [7:0] b, input int st);
    wait_hs2(1'b1, "tx_h2_rise");
    t_rise = t_seen;
    b = uP_data_in;
    repeat (st) @(negedge clk);
    uP_handshake_1 = 1'b1;
    wait_hs2(1'b0, "tx_h2_fall");
    repeat (st) @(negedge clk);
    uP_handshake_1 = 1'b0;
  endtask

  // One full transaction; expected reply derived from the packet rules and the reference memory.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                         input int st);
    logic [7:0] exp_q[$];
    logic [7:0] pkt [6];
    logic [7:0] got;
    int         w0, r0, t_fall;
    bit         ok_w, ok_r;
    pkt  = '{cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
    ok_w = 1'b0;
    ok_r = 1'b0;
    exp_q = {};
    if (cmd != 8'd1 && cmd != 8'd2) exp_q.push_back(8'h01);
    else if (int'(addr) >= NREG) exp_q.push_back(8'h02);
    else if (cmd == 8'd1) begin
      exp_q.push_back(8'h00);
      ok_w = 1'b1;
    end else begin
      exp_q.push_back(8'h00);
      for (int k = 0; k < 4; k++) exp_q.push_back(ref_mem[addr[4:0]][8*k +: 8]);
      ok_r = 1'b1;
    end
    w0 = wr_cnt;
    r0 = rd_cnt;
    uP_start = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(pkt[i], st);
    t_fall = t_seen;
    for (int i = 0; i < exp_q.size(); i++) begin
      recv_byte(got, st);
      if (i == 0) check("reply_latency", t_rise - t_fall, ok_r ? 32'd3 : 32'd2);
      check("reply_byte", {24'd0, got}, {24'd0, exp_q[i]});
    end
    wait_ack(1'b1, "ack_rise");
    repeat (6) @(negedge clk);
    check("no_extra_byte", {31'd0, uP_handshake_2}, 32'd0);
    check("ack_held", {31'd0, uP_ack}, 32'd1);
    uP_start = 1'b0;
    wait_ack(1'b0, "ack_fall");
    check("write_strobes", wr_cnt - w0, {31'd0, ok_w});
    check("read_strobes", rd_cnt - r0, {31'd0, ok_r});
    if (ok_w) begin
      check("write_addr", {24'd0, last_waddr}, {24'd0, addr});
      check("write_data", last_wdata, data);
      check("reg_address_hold", {24'd0, reg_address}, {24'd0, addr});
      ref_mem[addr[4:0]] = data;
    end
    if (ok_r) check("read_addr", {24'd0, last_raddr}, {24'd0, addr});
    check("protocol_rules", proto_err, 32'd0);
  endtask

  initial begin
    int w0, r0;
    logic [7:0] rc, ra;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, uP_ack}, 32'd0);
    check("rst_h2", {31'd0, uP_handshake_2}, 32'd0);
    check("rst_data_in", {24'd0, uP_data_in}, 32'd0);
    check("rst_reg_address", {24'd0, reg_address}, 32'd0);
    check("rst_reg_wdata", reg_wdata, 32'd0);
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_reg_read", {31'd0, reg_read}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int a = 0; a < NREG && n_fail < 10; a++)
      run_txn(8'd1, 8'(a), $urandom, int'($urandom_range(0, 2)));

    run_txn(8'd1, 8'd2, 32'h0506080B, 0);
    run_txn(8'd1, 8'd5, 32'hDEADBEEF, 0);
    run_txn(8'd2, 8'd5, 32'h12345678, 1);
    run_txn(8'd7, 8'd3, 32'hA5A5A5A5, 0);
    run_txn(8'd1, 8'd40, 32'h11111111, 0);
    run_txn(8'd1, 8'd31, 32'h31313131, 0);
    run_txn(8'd2, 8'd32, 32'h0, 0);
    run_txn(8'd2, 8'd31, 32'h0, 0);
    run_txn(8'd2, 8'd2, 32'h0, 0);

    // Abort after byte 3, mid-handshake of byte 4.
    w0 = wr_cnt;
    r0 = rd_cnt;
    uP_start = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 0);
    uP_data_out = 8'h44;
    uP_handshake_1 = 1'b1;
    wait_hs2(1'b1, "abort_rx_h2_rise");
    uP_start = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    check("abort_h2_low", {31'd0, uP_handshake_2}, 32'd0);
    check("abort_ack_low", {31'd0, uP_ack}, 32'd0);
    uP_handshake_1 = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    check("abort_no_write", wr_cnt - w0, 32'd0);
    check("abort_no_read", rd_cnt - r0, 32'd0);
    run_txn(8'd1, 8'd9, 32'hCAFEF00D, 0);
    run_txn(8'd2, 8'd9, 32'h0, 0);

    // Reset while driving the status byte of an error reply.
    uP_start = 1'b1;
    send_byte(8'd7, 0);
    send_byte(8'd3, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    wait_hs2(1'b1, "rst_tx_h2_rise");
    check("pre_rst_data_in", {24'd0, uP_data_in}, 32'h01);
    check("pre_rst_reg_address", {24'd0, reg_address}, 32'h03);
    #3 reset = 1'b0;
    #1;
    check("arst_ack", {31'd0, uP_ack}, 32'd0);
    check("arst_h2", {31'd0, uP_handshake_2}, 32'd0);
    check("arst_data_in", {24'd0, uP_data_in}, 32'd0);
    check("arst_reg_address", {24'd0, reg_address}, 32'd0);
    check("arst_reg_wdata", reg_wdata, 32'd0);
    check("arst_reg_write", {31'd0, reg_write}, 32'd0);
    check("arst_reg_read", {31'd0, reg_read}, 32'd0);
    uP_start = 1'b0;
    uP_handshake_1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 200 ns handshake phases.
    run_txn(8'd1, 8'd12, $urandom, 10);
    run_txn(8'd2, 8'd12, 32'h0, 10);

    for (int t = 0; t < 40 && n_fail < 10; t++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      rc  = (sel < 4) ? 8'd1 : (sel < 8) ? 8'd2 : 8'($urandom);
      ra  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, NREG - 1));
      run_txn(rc, ra, $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
